// File: rtl/apb4_host_bridge_if.sv
// APB4 bus bundle shared by the host bridge and any peripheral segment.
// The host modport drives request signals; the device modport drives responses.
interface apb4_intf #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) ();

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [2:0]            pprot;
  logic [AWIDTH-1:0]     paddr;
  logic [DWIDTH-1:0]     pwdata;
  logic [DWIDTH/8-1:0]   pstrb;
  logic [DWIDTH-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport host (
    output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport device (
    input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb4_host_bridge.sv
// APB4 host bridge: turns a valid/ready command/response port into single
// APB4 transfers (SETUP -> ACCESS -> response), one outstanding at a time.
// All outputs come straight from flops, so psel/penable cannot glitch.
// Optional ACCESS-phase timeout is enabled by defining APB4_HOST_TIMEOUT_EN;
// without it ACCESS waits for pready indefinitely and rsp_timeout is 0.
module apb4_host_bridge #(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AWIDTH-1:0]   cmd_addr,
  input  logic [DWIDTH-1:0]   cmd_wdata,
  input  logic [DWIDTH/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_slverr,
  output logic                rsp_timeout,
  apb4_intf.host              m_apb
);

  // Reject unusable configurations at elaboration time.
  if ((DWIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb4_host_bridge: DWIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]          state_q,      state_d;
  logic                cmd_ready_q,  cmd_ready_d;
  logic                psel_q,       psel_d;
  logic                penable_q,    penable_d;
  logic                pwrite_q,     pwrite_d;
  logic [2:0]          pprot_q,      pprot_d;
  logic [AWIDTH-1:0]   paddr_q,      paddr_d;
  logic [DWIDTH-1:0]   pwdata_q,     pwdata_d;
  logic [DWIDTH/8-1:0] pstrb_q,      pstrb_d;
  logic                rsp_valid_q,  rsp_valid_d;
  logic [DWIDTH-1:0]   rsp_rdata_q,  rsp_rdata_d;
  logic                rsp_slverr_q, rsp_slverr_d;

`ifdef APB4_HOST_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             rsp_timeout_q, rsp_timeout_d;
  logic [TMO_W-1:0] tmo_cnt_q,     tmo_cnt_d;
`endif

  // Next-state, command latch and response capture.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d      = state_q;
    pwrite_d     = pwrite_q;
    pprot_d      = pprot_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pstrb_d      = pstrb_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
`ifdef APB4_HOST_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          pwrite_d = cmd_write;
          pprot_d  = cmd_prot;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          // Reads must present an all-zero strobe on the bus.
          pstrb_d  = cmd_write ? cmd_strb : '0;
          state_d  = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef APB4_HOST_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        // pready wins over a timeout that would expire on the same edge.
        if (m_apb.pready) begin
          rsp_rdata_d  = pwrite_q ? '0 : m_apb.prdata;
          rsp_slverr_d = m_apb.pslverr;
`ifdef APB4_HOST_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          state_d = ST_RESP;
        end
`ifdef APB4_HOST_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          rsp_rdata_d   = '0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are decoded from the next state so they change
    // together with the state register.
    cmd_ready_d = (state_d == ST_IDLE);
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset drives every output low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      pprot_q      <= '0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      pprot_q      <= pprot_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pstrb_q      <= pstrb_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
    end
  end

`ifdef APB4_HOST_TIMEOUT_EN
  // ACCESS-phase wait counter and timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_slverr    = rsp_slverr_q;

  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pprot   = pprot_q;
  assign m_apb.paddr   = paddr_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pstrb   = pstrb_q;

endmodule
